bcd_display_loader: RTL
=======================

# bcd_display_loader

Sequential binary-to-BCD controller that feeds the 7-segment time multiplexer of the 8-bit RISC processor. On a start pulse it captures the two 8-bit ALU operands and the 16-bit result, then converts all three to decimal digits with a shared-sequencer double-dabble. It loads the multiplexer's digit inputs atomically, so the display never shows a partially converted value. It sits between the processor datapath (operand/result registers) and the display multiplexer's 4-bit digit inputs.

## Interface
Parameters:
- none. Widths are fixed: 8-bit operands (3 digits each) and 16-bit result (5 digits).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  conversion request; sampled only in IDLE
- a_in  in  8  operand A, unsigned
- b_in  in  8  operand B, unsigned
- result_in  in  16  ALU result, unsigned
- busy  out  1  high while a conversion is in progress (state != IDLE)
- done  out  1  one-cycle pulse when the digit outputs have just been updated
- res_d0..res_d4  out  4 each  result digits, units..ten-thousands; drive multiplexer inputs in1..in5
- a_d0..a_d2  out  4 each  operand A digits, units..hundreds; drive in1_A..in3_A
- b_d0..b_d2  out  4 each  operand B digits, units..hundreds; drive in4_B..in6_B

## Operation
- States: IDLE, SHIFT, COMMIT.
- **IDLE:**
  - On start=1, capture a_in, b_in and result_in into shift registers.
  - Clear the BCD scratch registers (A: 12 bits, B: 12 bits, R: 20 bits) and set the iteration counter to 0.
  - Go to SHIFT.
- **SHIFT:** one iteration per cycle.
  - In every scratch nibble, add 3 to any nibble >= 5.
  - Then shift the scratch left by 1, with the binary register's MSB entering the scratch LSB. The binary register shifts left too.
  - R converter: runs iterations 0..15.
  - A/B converters: run iterations 0..7 only, then hold.
  - Increment the counter. After iteration 15 completes, go to COMMIT.
- **COMMIT:**
  - Copy all scratch nibbles to the output digit registers in the same edge.
  - Set done=1 for one cycle and go to IDLE.
- Output digit registers change only in COMMIT; during SHIFT they hold the previous conversion.
- start while busy: ignored. Requests are neither queued nor latched.
- Inputs a_in/b_in/result_in are ignored after capture; changes during SHIFT have no effect.
- No overflow case: 255 fits 3 digits and 65535 fits 5 digits. Every output digit is always 0..9.
- **Reset (reset=0 at a rising edge):**
  - state=IDLE, counter=0, scratch=0.
  - All digit outputs=0, busy=0, done=0.
  - Reset dominates start.
  - Reset during SHIFT abandons the conversion; digits read 0, not the old value.

## Timing
- start sampled high at edge k (state IDLE): state=SHIFT and busy=1 after edge k.
- Edges k+1..k+16 perform iterations 0..15; state=COMMIT after edge k+16.
- Edge k+17: digits updated, done=1, busy=0, state=IDLE.
- Latency: start edge to valid digits = 17 cycles.
- done is high for exactly the one cycle after edge k+17.
- start held continuously high: the next capture occurs at edge k+18 (the cycle in which done=1). Throughput is one conversion per 18 cycles.
- busy is decoded from the state register (no combinational path from start).
- done is registered.

## Test plan
- **Reset:** hold reset=0 for 2 cycles with start=1 -> all 11 digits 0, busy=0, done=0; no conversion begins.
- **Maximum values:** a=255, b=0, result=65535, one-cycle start -> busy high for exactly 17 cycles, done pulse once; a_d2..a_d0=2,5,5, b=0,0,0, res_d4..res_d0=6,5,5,3,5.
- **Output stability:** after the max-values conversion, convert a=9, b=100, result=10009, changing the inputs to 0 one cycle after start -> digits stay 2,5,5/0,0,0/65535 through the conversion, then switch at once to 0,0,9 / 1,0,0 / 1,0,0,0,9.
- **start while busy:** pulse start at cycle 5 of SHIFT with different operands -> ignored; exactly one done pulse, first operands' digits.
- **Back-to-back and mid-run reset:**
  - start held high -> done pulses every 18 cycles.
  - reset=0 at iteration 8 -> digits 0, busy 0 next cycle.
  - A following start with a=128, b=64, result=300 -> 1,2,8 / 0,6,4 / 0,0,3,0,0.
- **Randomized:** 1000 random a/b/result vectors compared against a divide-by-10 reference model; every digit matches at each done pulse, and no digit is ever > 9.

Source files
------------

// File: rtl/bcd_display_loader.sv
// Captures two 8-bit operands and a 16-bit result, converts them to BCD with a
// shared double-dabble sequencer, and loads all display digits in one edge.
module bcd_display_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    input  logic [15:0] result_in,
    output logic        busy,
    output logic        done,
    output logic [3:0]  res_d0,
    output logic [3:0]  res_d1,
    output logic [3:0]  res_d2,
    output logic [3:0]  res_d3,
    output logic [3:0]  res_d4,
    output logic [3:0]  a_d0,
    output logic [3:0]  a_d1,
    output logic [3:0]  a_d2,
    output logic [3:0]  b_d0,
    output logic [3:0]  b_d1,
    output logic [3:0]  b_d2
);

    // Handshake: start is a request taken only while busy=0 (IDLE); once taken,
    // busy stays high until the COMMIT edge, and done pulses for exactly one
    // cycle when the digit outputs have just been replaced. No request queueing.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [7:0]  a_bin, b_bin;
    logic [15:0] r_bin;
    logic [11:0] a_scr, b_scr, a_adj, b_adj, a_dig, b_dig;
    logic [19:0] r_scr, r_adj, r_dig;

    function automatic logic [11:0] adj3_12(input logic [11:0] s);
        logic [11:0] t;
        t = s;
        for (int i = 0; i < 3; i++)
            if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
        return t;
    endfunction

    function automatic logic [19:0] adj3_20(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 5; i++)
            if (t[i*4 +: 4] >= 4'd5) t[i*4 +: 4] = t[i*4 +: 4] + 4'd3;
        return t;
    endfunction

    always_comb begin
        a_adj = adj3_12(a_scr);
        b_adj = adj3_12(b_scr);
        r_adj = adj3_20(r_scr);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            a_bin <= 8'd0;
            b_bin <= 8'd0;
            r_bin <= 16'd0;
            a_scr <= 12'd0;
            b_scr <= 12'd0;
            r_scr <= 20'd0;
            a_dig <= 12'd0;
            b_dig <= 12'd0;
            r_dig <= 20'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_bin <= a_in;
                        b_bin <= b_in;
                        r_bin <= result_in;
                        a_scr <= 12'd0;
                        b_scr <= 12'd0;
                        r_scr <= 20'd0;
                        cnt   <= 4'd0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scr <= {r_adj[18:0], r_bin[15]};
                    r_bin <= {r_bin[14:0], 1'b0};
                    // Operand converters only need 8 iterations, then hold.
                    if (!cnt[3]) begin
                        a_scr <= {a_adj[10:0], a_bin[7]};
                        a_bin <= {a_bin[6:0], 1'b0};
                        b_scr <= {b_adj[10:0], b_bin[7]};
                        b_bin <= {b_bin[6:0], 1'b0};
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    a_dig <= a_scr;
                    b_dig <= b_scr;
                    r_dig <= r_scr;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state != ST_IDLE);
    assign a_d0   = a_dig[3:0];
    assign a_d1   = a_dig[7:4];
    assign a_d2   = a_dig[11:8];
    assign b_d0   = b_dig[3:0];
    assign b_d1   = b_dig[7:4];
    assign b_d2   = b_dig[11:8];
    assign res_d0 = r_dig[3:0];
    assign res_d1 = r_dig[7:4];
    assign res_d2 = r_dig[11:8];
    assign res_d3 = r_dig[15:12];
    assign res_d4 = r_dig[19:16];

endmodule
